prog_loader: RTL and testbench
==============================

# prog_loader

Bus-master program loader that fills the CPU RAM from a byte stream before or between program runs. It is the writer side of the RAM's `mar_load` / `ram_load` protocol, which the controller otherwise uses only for fetch and `STORE`. The loader accepts a length-prefixed stream of 16-bit words over a valid/ready byte interface and writes them to consecutive RAM addresses. While loading, it holds the CPU off the bus.

## Interface

Parameters:
- `ADDR_W`, 12: RAM address width; matches the MAR width.
- `BASE_ADDR`, 0: RAM address of the first loaded word.
- `MAX_WORDS`, 256: largest accepted word count; matches the RAM depth.

Ports:
- `clk`, in, 1: system clock; all state updates on posedge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `byte_valid`, in, 1: `byte_data` is valid.
- `byte_data`, in, 8: stream byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `bus_out`, out, 16: value the loader drives onto the shared bus.
- `bus_drive`, out, 1: bus mux selects `bus_out`; takes priority over all CPU sources.
- `mar_load`, out, 1: RAM MAR load strobe.
- `ram_load`, out, 1: RAM write strobe.
- `cpu_hold`, out, 1: freezes the controller stage counter and PC.
- `done`, out, 1: one-cycle pulse when a load ends, whether it succeeded or failed.
- `err`, out, 1: sticky error flag; cleared on the next accepted `start`.

## Operation

- A byte transfer occurs on a posedge where `byte_valid && byte_ready` are both high.
- Stream format, all fields high byte first:
  - LEN: 16-bit word count N.
  - N data words.
  - optional checksum byte (see Configuration).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, SET_ADDR, WRITE, CSUM, FIN.
- IDLE:
  - `start=1` → LEN_HI.
  - Clear `err`, the address counter and the word counter.
  - Raise `cpu_hold`.
- LEN_HI → LEN_LO on a transfer. LEN_LO → next state on a transfer:
  - N=0 → CSUM if enabled, else FIN.
  - N>MAX_WORDS → set `err`, go to FIN. No RAM writes occur.
  - Otherwise → DATA_HI.
- DATA_HI → DATA_LO on a transfer; the byte goes to `word[15:8]`.
- DATA_LO → SET_ADDR on a transfer; the byte goes to `word[7:0]`.
- SET_ADDR:
  - Outputs: `bus_drive=1`, `mar_load=1`, `bus_out={zeros, BASE_ADDR+idx}`.
  - Always → WRITE.
- WRITE:
  - Outputs: `bus_drive=1`, `ram_load=1`, `bus_out=word`.
  - Increment idx.
  - Last word → CSUM if enabled, else FIN; otherwise → DATA_HI.
- FIN: pulse `done`, drop `cpu_hold`, → IDLE.
- Address arithmetic: `BASE_ADDR+idx` is computed modulo 2^ADDR_W, so addresses wrap to 0.
- `start` outside IDLE is ignored.
- `byte_valid` while `byte_ready=0` is not consumed.

## Timing

- Outputs are Moore-decoded from the registered state; there are no combinational paths from inputs to outputs.
- `byte_ready=1` only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
- `mar_load` and `ram_load` are never high in the same cycle. The RAM gives `mar_load` priority, so the two strobes must sit in separate cycles.
- Per word: 2 transfer cycles (minimum) + SET_ADDR + WRITE, i.e. 4 cycles at full input rate.
- Minimum total load time: 1 (IDLE→LEN_HI) + 2 + 4N + (1 if checksum) + 1 (FIN) cycles.
- `cpu_hold` is high from the cycle after `start` is accepted through FIN inclusive.
- Reset values: state IDLE; all outputs 0; `bus_out=0`.
- Reset mid-load: all outputs go to 0 immediately (asynchronous). RAM contents already written stay as written.

## Configuration

- `PROG_LOADER_CSUM_EN` defined:
  - An 8-bit running XOR of all data bytes (not LEN bytes) is kept.
  - CSUM accepts one byte; a mismatch sets `err`.
  - CSUM → FIN.
- `PROG_LOADER_CSUM_EN` undefined:
  - No CSUM state and no checksum register.
  - The stream ends after the last data byte.

## Test plan

- N=2, words 0x1A0D and 0x4C0E, full-rate valid:
  - `mar_load` with bus 0x000, then `ram_load` 0x1A0D.
  - `mar_load` with bus 0x001, then `ram_load` 0x4C0E.
  - One `done` pulse, `err=0`, `cpu_hold` low after FIN.
- Same stream with `byte_valid` toggling every other cycle → identical RAM writes. `byte_ready` never drops during DATA_HI/LO waits.
- LEN=0x0101 (257 > MAX_WORDS) → no `mar_load`/`ram_load` at all; `err=1`; `done` pulses.
- LEN=0 → no writes; `done` pulses (after the checksum byte 0x00 when `PROG_LOADER_CSUM_EN` is defined).
- `PROG_LOADER_CSUM_EN` defined, word 0x1234:
  - checksum byte 0x26 → `err=0`.
  - checksum byte 0x27 → `err=1`.
  - The RAM write occurs in both cases.
- `rst_n` asserted during the WRITE of word 1 of 3 → `ram_load`, `cpu_hold` and `bus_drive` go to 0 asynchronously. After release the state is IDLE, and a fresh `start` reloads correctly from `BASE_ADDR`.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte-stream loader that writes 16-bit words into RAM.
// Define PROG_LOADER_CSUM_EN to add a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        mar_load,
  output logic        ram_load,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    SET_ADDR,
    WRITE,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

`ifdef PROG_LOADER_CSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = FIN;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t            state;
  state_t            nxt;
  logic [15:0]       len;
  logic [15:0]       idx;
  logic [15:0]       word;
  logic [15:0]       len_in;
  logic [15:0]       idx_inc;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              too_long;
  logic              nx_ready;
  logic              nx_drive;
  logic              nx_mar;
  logic              nx_ram;
  logic [15:0]       nx_bus;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer     = byte_valid && byte_ready;
  assign len_in   = {len[15:8], byte_data};
  assign too_long = {1'b0, len_in} > MAX_N;
  assign idx_inc  = idx + 16'd1;
  // Address wraps naturally at the ADDR_W boundary
  assign addr     = ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (start) nxt = LEN_HI;
      LEN_HI:   if (xfer) nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_in == '0)  nxt = TAIL;
          else if (too_long) nxt = FIN;
          else               nxt = DATA_HI;
        end
      end
      DATA_HI:  if (xfer) nxt = DATA_LO;
      DATA_LO:  if (xfer) nxt = SET_ADDR;
      SET_ADDR: nxt = WRITE;
      WRITE:    nxt = (idx_inc == len) ? TAIL : DATA_HI;
`ifdef PROG_LOADER_CSUM_EN
      CSUM:     if (xfer) nxt = FIN;
`endif
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered
  always_comb begin
    nx_ready = 1'b0;
    nx_drive = 1'b0;
    nx_mar   = 1'b0;
    nx_ram   = 1'b0;
    nx_bus   = '0;
    unique case (1'b1)
      nxt == LEN_HI,
      nxt == LEN_LO,
`ifdef PROG_LOADER_CSUM_EN
      nxt == CSUM,
`endif
      nxt == DATA_HI,
      nxt == DATA_LO: nx_ready = 1'b1;
      nxt == SET_ADDR: begin
        nx_drive = 1'b1;
        nx_mar   = 1'b1;
        nx_bus   = 16'(addr);
      end
      nxt == WRITE: begin
        nx_drive = 1'b1;
        nx_ram   = 1'b1;
        nx_bus   = word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      word       <= '0;
      err        <= 1'b0;
      byte_ready <= 1'b0;
      bus_out    <= '0;
      bus_drive  <= 1'b0;
      mar_load   <= 1'b0;
      ram_load   <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= nx_ready;
      bus_out    <= nx_bus;
      bus_drive  <= nx_drive;
      mar_load   <= nx_mar;
      ram_load   <= nx_ram;
      cpu_hold   <= nxt != IDLE;
      done       <= nxt == FIN;
      unique case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            idx <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum <= '0;
`endif
          end
        end
        LEN_HI: if (xfer) len[15:8] <= byte_data;
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= byte_data;
            if (too_long) err <= 1'b1;
          end
        end
        DATA_HI: begin
          if (xfer) begin
            word[15:8] <= byte_data;
`ifdef PROG_LOADER_CSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        DATA_LO: begin
          if (xfer) begin
            word[7:0] <= byte_data;
`ifdef PROG_LOADER_CSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        WRITE: idx <= idx_inc;
`ifdef PROG_LOADER_CSUM_EN
        CSUM: if (xfer && byte_data != csum) err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked against a
// queue-based model of the expected RAM writes.
module tb_prog_loader;

  localparam int BASE = 4000;
  localparam int MAXW = 256;
`ifdef PROG_LOADER_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [15:0] bus_out;
  logic        bus_drive;
  logic        mar_load;
  logic        ram_load;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int bad_cnt = 0;
  logic [15:0] cur_addr = '0;
  logic [15:0] obs_a[$];
  logic [15:0] obs_d[$];
  logic [15:0] wbuf[$];

  prog_loader #(
    .ADDR_W(12),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .bus_out(bus_out),
    .bus_drive(bus_drive),
    .mar_load(mar_load),
    .ram_load(ram_load),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start) start_cyc = cyc;
      if (mar_load && ram_load) bad_cnt++;
      if ((mar_load || ram_load) && !(bus_drive && cpu_hold)) bad_cnt++;
      if (byte_ready && bus_drive) bad_cnt++;
      if (mar_load) cur_addr = bus_out;
      if (ram_load) begin
        obs_a.push_back(cur_addr);
        obs_d.push_back(bus_out);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gm);
    int g;
    int k;
    g = (gm == 1) ? 1 : (gm == 2) ? int'($urandom_range(0, 3)) : 0;
    if (g > 0) begin
      byte_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!byte_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int len, input int gm, input bit bad,
                          input bit lat);
    int nw;
    int d0;
    int w0;
    int b0;
    int k;
    int c;
    logic [7:0]  cs;
    logic [15:0] l16;
    logic [15:0] w;
    nw  = (len <= MAXW) ? len : 0;
    c   = (CS && len <= MAXW) ? 1 : 0;
    l16 = 16'(len);
    d0  = done_cnt;
    w0  = obs_d.size();
    b0  = bad_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(l16[15:8], gm);
    send_byte(l16[7:0], gm);
    cs = '0;
    for (int i = 0; i < nw; i++) begin
      w = wbuf[i];
      send_byte(w[15:8], gm);
      send_byte(w[7:0], gm);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    if (c == 1) send_byte(bad ? (cs ^ 8'h01) : cs, gm);
    byte_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err", {31'b0, err}, ((len > MAXW) || (c == 1 && bad)) ? 1 : 0);
    chk("hold_after", {31'b0, cpu_hold}, 0);
    chk("n_writes", obs_d.size() - w0, nw);
    for (int i = 0; i < nw && (w0 + i) < obs_d.size(); i++) begin
      chk("wr_addr", obs_a[w0 + i], 16'((BASE + i) % 4096));
      chk("wr_data", obs_d[w0 + i], wbuf[i]);
    end
    chk("strobes", bad_cnt - b0, 0);
    if (lat) chk("latency", done_cyc - start_cyc, 3 + 4 * nw + c);
  endtask

  initial begin
    int n;
    int gm;
    int w0;
    rst_n      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_ready", {31'b0, byte_ready}, 0);
    chk("rst_bus", {16'b0, bus_out}, 0);
    chk("rst_drive", {31'b0, bus_drive}, 0);
    chk("rst_strobe", {30'b0, mar_load, ram_load}, 0);
    chk("rst_hold", {31'b0, cpu_hold}, 0);
    chk("rst_done_err", {30'b0, done, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wbuf = {16'h1A0D, 16'h4C0E};
    run_load(2, 0, 1'b0, 1'b1);
    run_load(2, 1, 1'b0, 1'b0);
    run_load(257, 0, 1'b0, 1'b1);
    run_load(0, 0, 1'b0, 1'b1);
    wbuf = {16'h1234};
    run_load(1, 0, 1'b0, 1'b1);
    run_load(1, 0, 1'b1, 1'b1);

    wbuf.delete();
    for (int i = 0; i < MAXW; i++) wbuf.push_back(16'($urandom));
    run_load(MAXW, 0, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      n  = $urandom_range(1, 8);
      gm = $urandom_range(0, 2);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
      run_load(n, gm, 1'($urandom_range(0, 1)), gm == 0);
    end

    wbuf = {16'hA1B2, 16'hC3D4, 16'hE5F6};
    w0 = obs_d.size();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wr1_ram", {31'b0, ram_load}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ram", {31'b0, ram_load}, 0);
    chk("arst_hold", {31'b0, cpu_hold}, 0);
    chk("arst_drive", {31'b0, bus_drive}, 0);
    chk("arst_nwr", obs_d.size() - w0, 1);
    if (obs_d.size() > w0) begin
      chk("arst_data", obs_d[w0], 16'hA1B2);
      chk("arst_addr", obs_a[w0], 16'(BASE % 4096));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_load(3, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
